// File: rtl/ram_pixel_reader_pkg.sv
// ---------------------------------------------------------------------------
// ram_pixel_reader_pkg
// Shared constants for the image-RAM pixel reader:
//   - default address / pixel widths
//   - image geometry constants
//   - FSM state encoding
//   - small helper for counter widths
// No ports (package).
// ---------------------------------------------------------------------------
package ram_pixel_reader_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 8;

    localparam int IMG_W = 512;
    localparam int IMG_H = 512;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Bits needed to hold an occupancy value of 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_pixel_reader_if.sv
// ---------------------------------------------------------------------------
// ram_pixel_reader_if
// Bundles the RAM read bus and the outgoing pixel stream.
//   RAM side   : ren, wen, a (reader -> RAM), q (RAM -> reader)
//   Stream side: out_valid, out_data, out_last (reader -> sink),
//                out_ready (sink -> reader)
// Modports:
//   master - the pixel reader
//   slave  - the RAM plus the downstream sink
// ---------------------------------------------------------------------------
interface ram_pixel_reader_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output ren, wen, a, out_valid, out_data, out_last,
        input  q, out_ready
    );

    modport slave (
        input  ren, wen, a, out_valid, out_data, out_last,
        output q, out_ready
    );
endinterface

// File: rtl/ram_pixel_reader_fifo.sv
// ---------------------------------------------------------------------------
// ram_pixel_reader_fifo
// Small synchronous FIFO used as the output buffer of the pixel reader.
// Head entry is visible combinationally on o_rdata (first-word fall-through).
// Simultaneous push and pop on a full FIFO is accepted.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (empties FIFO)
//   i_push, i_wdata  write strobe and data
//   i_pop            remove head entry
//   o_rdata          head entry
//   o_full, o_empty  status flags
//   o_count          current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module ram_pixel_reader_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_pixel_reader.sv
// ---------------------------------------------------------------------------
// ram_pixel_reader
// Read-side initiator for the single-port image RAM (1-cycle registered read,
// Q=0 when REN=0). A START pulse in IDLE latches BASE_ADDR / PIX_CNT; the
// block then reads PIX_CNT consecutive addresses (wrapping mod 2^ADDR_W) and
// presents the pixels in order on a valid/ready stream, OUT_LAST on the
// final one. Reads are credit-limited so the output FIFO never overflows.
// Never writes the RAM.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (aborts transfer)
//   i_start           one-cycle request, sampled only in IDLE
//   i_base_addr       first address
//   i_pix_cnt         pixel count, 0..2^ADDR_W
//   o_busy            high from accepted START through the DONE cycle
//   o_done            one-cycle completion pulse
//   o_stall_cnt       (RAM_PIXEL_READER_PERF_EN only) saturating count of
//                     busy cycles with OUT_VALID=1 and OUT_READY=0
//   io_bus            RAM bus + output stream (ram_pixel_reader_if.master)
// Optional feature macro: RAM_PIXEL_READER_PERF_EN
// ---------------------------------------------------------------------------
module ram_pixel_reader
    import ram_pixel_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_pix_cnt,
    output logic              o_busy,
    output logic              o_done,
`ifdef RAM_PIXEL_READER_PERF_EN
    output logic [31:0]       o_stall_cnt,
`endif
    ram_pixel_reader_if.master io_bus
);

    localparam int CNT_W = occ_w(FIFO_DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;        // next address to issue
    logic [ADDR_W-1:0] r_last_addr;   // final address of the run
    logic [ADDR_W-1:0] r_a;           // last issued address, shown while idle
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_start_ok;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occ;
    logic [CNT_W:0]    w_limit;
    logic [DATA_W:0]   w_head;

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign w_valid    = !w_empty;
    assign w_pop      = w_valid && io_bus.out_ready;

    // Credit rule: occupancy after this cycle (FIFO + in-flight + new read -
    // pop) must stay within FIFO_DEPTH. Written as occ < DEPTH + pop to keep
    // the arithmetic unsigned.
    assign w_occ   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_limit = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};

    // The full term is implied by the credit rule; kept as a local guard.
    assign w_issue = (r_state == ST_RUN) && (w_occ < w_limit) && (!w_full || w_pop);

    // Comparing against the latched last address handles a full 2^ADDR_W run
    // too: every address is visited once and the match happens only at the end.
    assign w_issue_last = (r_addr == r_last_addr);

    // RAM bus
    assign io_bus.ren = w_issue;
    assign io_bus.wen = 1'b0;
    assign io_bus.a   = w_issue ? r_addr : r_a;

    // Stream from FIFO head; data forced to zero while empty.
    assign io_bus.out_valid = w_valid;
    assign io_bus.out_data  = w_valid ? w_head[DATA_W-1:0] : '0;
    assign io_bus.out_last  = w_valid && w_head[DATA_W];

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_FIN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_last_addr     <= '0;
            r_a             <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            if (w_issue) begin
                r_a    <= r_addr;
                r_addr <= r_addr + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_addr      <= i_base_addr;
                        r_last_addr <= i_base_addr + i_pix_cnt[ADDR_W-1:0] - 1'b1;
                        r_state     <= (i_pix_cnt == '0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_issue_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty && !r_inflight) r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data lands one cycle after REN; a reset clears r_inflight so a
    // read that was in flight is dropped.
    ram_pixel_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_wdata ({r_inflight_last, io_bus.q}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef RAM_PIXEL_READER_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (o_busy && w_valid && !io_bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ram_pixel_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_pixel_reader
// Scoreboard bench: each transfer pushes its expected address sequence and
// expected {last, pixel} sequence into queues; a negedge monitor pops and
// compares whenever the DUT issues a read or hands over a pixel.
// ---------------------------------------------------------------------------
module tb_ram_pixel_reader;
    import ram_pixel_reader_pkg::*;

    localparam int AW    = 18;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   cnt = '0;
    logic          rdy = 1'b1;
    logic          busy;
    logic          done;
`ifdef RAM_PIXEL_READER_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    ram_pixel_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_pixel_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .i_pix_cnt   (cnt),
        .o_busy      (busy),
        .o_done      (done),
`ifdef RAM_PIXEL_READER_PERF_EN
        .o_stall_cnt (stall_cnt),
`endif
        .io_bus      (bus)
    );

    initial forever #5 clk = ~clk;

    // Image RAM contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] ad);
        return (ad[7:0] ^ 8'hA5) + {6'd0, ad[17:16]};
    endfunction

    // RAM model: registered read, Q=0 when not reading.
    always @(posedge clk) bus.q <= bus.ren ? mem(bus.a) : '0;
    assign bus.out_ready = rdy;

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    logic [AW-1:0] addr_q[$];
    logic [DW:0]   exp_q[$];

    int          cyc = 0;
    int          first_ren_cyc = -1, first_val_cyc = -1;
    int          done_cnt = 0, done_cyc = -1, last_cyc = -1;
    int          acc = 0, stall_seen = 0, issued = 0, accepted = 0;
    logic        prev_hold = 1'b0;
    logic [DW:0] prev_out = '0;
    logic [31:0] stall_at_done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("wen_zero", {31'd0, bus.wen}, 32'd0);
            if (bus.ren) begin
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                issued++;
                if (addr_q.size() == 0) chk("ren_unexpected", {31'd0, bus.ren}, 32'd0);
                else chk("addr", {14'd0, bus.a}, {14'd0, addr_q.pop_front()});
            end
            if (prev_hold) begin
                chk("stall_stable", {23'd0, bus.out_last, bus.out_data}, {23'd0, prev_out});
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            if (bus.out_valid) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (busy && !bus.out_ready) stall_seen++;
                if (bus.out_ready) begin
                    accepted++;
                    acc++;
                    if (exp_q.size() == 0) chk("out_unexpected", {31'd0, bus.out_valid}, 32'd0);
                    else chk("out_data_last", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_q.pop_front()});
                    if (bus.out_last) last_cyc = cyc;
                end
            end
            if (bus.ren) chk("credit", {31'd0, (issued - accepted) <= DEPTH}, 32'd1);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = {bus.out_last, bus.out_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef RAM_PIXEL_READER_PERF_EN
                stall_at_done = stall_cnt;
`endif
            end
        end
    end

    // mode 0: ready always; mode 1: ready 1,0,0,1 repeating;
    // mode 2: ready held low until 7 stall cycles have been seen.
    function automatic logic ready_pat(input int mode, input int t);
        case (mode)
            1:       return (t % 4 == 0) || (t % 4 == 3);
            2:       return stall_seen >= 7;
            default: return 1'b1;
        endcase
    endfunction

    task automatic xfer(input logic [AW-1:0] b, input logic [AW:0] n, input int mode);
        int t;
        int sc;
        logic [AW-1:0] ad;
        for (int i = 0; i < int'(n); i++) begin
            ad = b + i[AW-1:0];
            addr_q.push_back(ad);
            exp_q.push_back({(i == int'(n) - 1), mem(ad)});
        end
        first_ren_cyc = -1; first_val_cyc = -1; done_cnt = 0; done_cyc = -1;
        last_cyc = -1; stall_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; base = b; cnt = n; sc = cyc;
        rdy = ready_pat(mode, 0);
        t = 0;
        @(posedge clk); #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (done_cnt == 0 && t < 300) begin
            rdy = ready_pat(mode, t + 1);
            // A second START mid-transfer must be ignored.
            if (n >= 4 && t == 2) begin
                start = 1'b1; base = ~b; cnt = 7;
            end else begin
                start = 1'b0; base = b; cnt = n;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        chk("busy_low_after_done", {31'd0, busy}, 32'd0);
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
        if (n == 0) begin
            chk("zero_no_ren", first_ren_cyc, -1);
            chk("zero_no_valid", first_val_cyc, -1);
            chk("zero_done_cyc", done_cyc, sc + 1);
        end else begin
            chk("first_ren_cyc", first_ren_cyc, sc + 1);
            chk("first_valid_cyc", first_val_cyc, sc + 3);
            if (mode == 0) chk("last_cyc", last_cyc, sc + 2 + int'(n));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_ren"},   {31'd0, bus.ren}, 32'd0);
        chk({tag, "_wen"},   {31'd0, bus.wen}, 32'd0);
        chk({tag, "_a"},     {14'd0, bus.a}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, bus.out_data}, 32'd0);
        chk({tag, "_last"},  {31'd0, bus.out_last}, 32'd0);
    endtask

    task automatic rst_mid();
        int t;
        logic [AW-1:0] ad;
        for (int i = 0; i < 8; i++) begin
            ad = 18'h00100 + i[AW-1:0];
            addr_q.push_back(ad);
            exp_q.push_back({(i == 7), mem(ad)});
        end
        acc = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base = 18'h00100; cnt = 8; rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (acc < 3 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        rdy = 1'b0;
        chk("rst_pre_acc", acc, 3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        addr_q.delete(); exp_q.delete();
        issued = 0; accepted = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midrst");
        chk("midrst_no_done", done_cnt, 0);
        rdy = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        xfer(18'h00010, 4, 0);
        xfer(18'h00010, 4, 1);
        xfer(18'h3FFFE, 4, 0);
        xfer(18'h00000, 0, 0);
        rst_mid();
        xfer(18'h00100, 8, 0);
        xfer(18'h00040, 8, 1);
        xfer(18'h00020, 5, 2);
`ifdef RAM_PIXEL_READER_PERF_EN
        chk("stall_cnt_at_done", stall_at_done, 32'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ram_pixel_reader.md
Name: ram_pixel_reader

Overview:
- Read-side initiator for the single-port image RAM, which has a 1-cycle registered read and returns Q=0 whenever REN=0.
- On a START pulse it reads a contiguous run of PIX_CNT pixels from BASE_ADDR and presents them in address order on a valid/ready stream, with backpressure.
- Sits between the image RAM and the halftone processing pipeline.
- Never writes: WEN is held at 0.

Parameters:
- ADDR_W, 18, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 2, output buffer entries; must be 2 or more.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  first address; latched on accepted START.
- PIX_CNT  in  ADDR_W+1  pixel count (0..2^ADDR_W); latched on accepted START.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse when transfer completes.
- REN  out  1  RAM read enable.
- WEN  out  1  RAM write enable; constant 0.
- A  out  ADDR_W  RAM address.
- Q  in  DATA_W  RAM read data.
- OUT_VALID  out  1  stream data valid.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  DATA_W  pixel.
- OUT_LAST  out  1  marks the final pixel of the transfer.

Behaviour:
- Reset values: BUSY=0, DONE=0, REN=0, WEN=0, A=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0. The FIFO is emptied, the in-flight flag is cleared and state=IDLE.
- Reset mid-transfer aborts immediately. Any read in flight is discarded: its Q is never written to the FIFO. DONE is not pulsed.
- State IDLE:
  - START=1 latches BASE_ADDR, PIX_CNT and LAST_ADDR = BASE_ADDR + PIX_CNT - 1 (mod 2^ADDR_W); sets BUSY=1.
  - Goes to RUN, or to FIN if PIX_CNT=0.
- State RUN:
  - Issue rule: REN=1 in a cycle iff remaining_issue>0 and (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = OUT_VALID & OUT_READY.
  - On issue, A = the current address. The address then increments, wrapping from 2^ADDR_W-1 to 0. remaining_issue decrements.
  - When REN=0, A holds its value.
  - Goes to DRAIN once the last read has been issued.
- In-flight tracking: inflight=1 in the cycle after REN=1. In that cycle Q is pushed into the FIFO, together with a last flag that is set iff it is the final pixel.
- State DRAIN: stays until FIFO empty and inflight=0, then goes to FIN.
- State FIN: DONE=1 for one cycle, BUSY=0 next, state returns to IDLE. PIX_CNT=0 produces DONE the cycle after START with no REN activity.
- START while BUSY, or while in FIN, is ignored.
- Latency: START high in cycle 0 -> REN=1, A=BASE_ADDR in cycle 1 -> Q valid in cycle 2 -> OUT_VALID=1 in cycle 3.
- Throughput: 1 pixel per cycle while OUT_READY=1.
- Stream rules:
  - OUT_DATA and OUT_LAST are driven from the FIFO head.
  - Once OUT_VALID=1, OUT_DATA and OUT_LAST hold stable until accepted.
  - Simultaneous push and pop on a full FIFO is legal; the credit rule guarantees no overflow.
- Boundaries:
  - PIX_CNT = 2^ADDR_W reads the whole memory, wrapping through 0, then stops.
  - FIFO never overflows. OUT_VALID=0 whenever the FIFO is empty.

Optional Feature:
- Macro: RAM_PIXEL_READER_PERF_EN.
- Defined: adds output port STALL_CNT [31:0]. It is cleared on RST and on accepted START. It increments, saturating, each cycle BUSY=1 and OUT_VALID=1 and OUT_READY=0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN, FIN)
  - default ADDR_W=18 and DATA_W=8
  - IMG_W=512 and IMG_H=512 constants
- One natural sub-module: ram_pixel_reader_fifo, a synchronous FIFO of depth FIFO_DEPTH and width DATA_W+1 (data plus last flag). It provides push, pop, full, empty and count.

Test Plan:
- RST, then START with BASE_ADDR=0x00010, PIX_CNT=4, OUT_READY=1 -> A=0x10..0x13 in cycles 1..4. OUT_DATA = mem[0x10..0x13] in cycles 3..6, OUT_LAST in cycle 6. DONE pulse once, BUSY low after.
- Same transfer with OUT_READY toggling 1,0,0,1,... -> data order and values preserved, no duplicates or losses. OUT_DATA stable while stalled. REN never raises fifo_count+inflight above 2.
- BASE_ADDR=0x3FFFE, PIX_CNT=4 -> A sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- PIX_CNT=0 -> REN stays 0, OUT_VALID stays 0, DONE pulses in cycle 1.
- RST asserted while 3 of 8 pixels delivered and OUT_READY=0 -> next cycle all outputs at reset values, no DONE. A new START then delivers a full clean transfer.
- PERF_EN build: 5-pixel transfer with OUT_READY low for 7 cycles while valid -> STALL_CNT=7 at DONE.
